// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the six-digit seven-segment scan driver:
//   - GLYPH_TBL : BCD nibble -> active-low {g,f,e,d,c,b,a}; 10..15 are blank
//   - field_e   : which time field a digit belongs to / which field blinks
//   - SEG_OFF / AN_OFF : all-dark patterns for the segment and anode buses
// ----------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HR   = 2'd2,
        FLD_NONE = 2'd3
    } field_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [5:0] AN_OFF  = 6'h3F;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,   // 0..4
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10,   // 5..9
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,   // 10..14 blank
        7'h7F                                // 15 blank
    };

endpackage

// File: rtl/seg_scan_if.sv
// ----------------------------------------------------------------------------
// seg_scan_if
// Bundle between the clock datapath (master) and the display driver (slave).
//   tm        : BCD time {hr,mn,sd}, each byte {tens,ones}
//   blink_en  : edit mode active
//   blink_sel : field being edited (0 sec, 1 min, 2 hr, 3 none)
//   an        : active-low one-hot digit enables
//   seg       : active-low segments {dp,g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
interface seg_scan_if;
    logic [23:0] tm;
    logic        blink_en;
    logic [1:0]  blink_sel;
    logic [5:0]  an;
    logic [7:0]  seg;

    modport master (output tm, blink_en, blink_sel, input an, seg);
    modport slave  (input tm, blink_en, blink_sel, output an, seg);
endinterface

// File: rtl/seg_scan_bcd7seg.sv
// ----------------------------------------------------------------------------
// bcd7seg
// Combinational BCD nibble to active-low seven-segment glyph.
//   bcd   : input nibble
//   seg_n : {g,f,e,d,c,b,a}, active-low; non-decimal nibbles are blank
// ----------------------------------------------------------------------------
module bcd7seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    assign seg_n = GLYPH_TBL[bcd];

endmodule

// File: rtl/seg_scan.sv
// ----------------------------------------------------------------------------
// seg_scan
// Time-multiplexed six-digit common-anode display driver.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : seg_scan_if.slave (tm, blink_en, blink_sel in; an, seg out)
// One digit per slot of SCAN_DIV cycles, digits 0..5 then wrap. The time word
// is snapshotted once per frame so a frame never mixes two times. The first
// cycle of every slot keeps all anodes off to avoid ghosting between digits.
// ----------------------------------------------------------------------------
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] slot_cnt;
    logic [2:0]    dig_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic [23:0]   snap;
    logic          first_q;     // set by reset: load snapshot on first clock
    logic [5:0]    an_q;
    logic [7:0]    seg_q;

    logic          slot_end;
    logic          frame_end;
    logic          blink_end;
    logic [3:0]    nibble;
    logic [6:0]    glyph_n;
    field_e        dig_fld;
    logic          blank;
    logic          dp_n;
    logic [7:0]    seg_next;
    logic [5:0]    an_next;

    assign slot_end  = (slot_cnt == SW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (dig_idx == 3'd5);
    assign blink_end = (blink_cnt == BW'(BLINK_DIV - 1));

    assign nibble = snap[{dig_idx, 2'b00} +: 4];

    bcd7seg u_dec (
        .bcd   (nibble),
        .seg_n (glyph_n)
    );

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // here via defaults at the top, so no latch can be inferred.
    always_comb begin
        seg_next = SEG_OFF;
        an_next  = AN_OFF;
        // Digit pairs {0,1},{2,3},{4,5} map to fields sec, min, hr.
        dig_fld  = field_e'(dig_idx[2:1]);
        blank    = bus.blink_en && blink_ph && (field_e'(bus.blink_sel) == dig_fld);
        // Separator dots sit on the minute-ones and hour-ones digits.
        dp_n     = !(((dig_idx == 3'd2) || (dig_idx == 3'd4)) && !blink_ph);
        if (!blank)
            seg_next = {dp_n, glyph_n};
        if (slot_cnt != '0)
            an_next = ~(6'b000001 << dig_idx);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other one, regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt  <= '0;
            dig_idx   <= 3'd0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            snap      <= 24'h0;
            first_q   <= 1'b1;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
        end else begin
            first_q <= 1'b0;

            if (slot_end) begin
                slot_cnt <= '0;
                dig_idx  <= (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end

            if (frame_end || first_q)
                snap <= bus.tm;

            if (blink_end) begin
                blink_cnt <= '0;
                blink_ph  <= !blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            an_q  <= an_next;
            seg_q <= seg_next;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;

endmodule
